dl_shifter_pipe: RTL and testbench
==================================

# dl_shifter_pipe

Parameterised, pipelined multi-mode barrel shifter with valid/ready handshake on both sides. It supports logical left, logical right, arithmetic right and rotate right over a configurable data width. The logarithmic shift network is split across a configurable number of register stages. It sits in the design library as the shared shift engine for execute-stage ALUs and wide datapath blocks that need timing closure beyond a single-cycle shifter.

## Interface
- NUM_BITS, 32: data width; must be a power of two, ≥ 2.
- NUM_STAGES, 2: pipeline register stages, range 1..$clog2(NUM_BITS).
- NUM_SHIFT_BITS (localparam), $clog2(NUM_BITS): shift-amount width.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous; invalidates all in-flight operations.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- in_data  input  NUM_BITS  operand.
- in_shamt  input  NUM_SHIFT_BITS  shift amount.
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  NUM_BITS  shifted result.

## Operation
- Shift network: NUM_SHIFT_BITS binary levels; level i shifts by 2**i when shamt bit i is set.
- Stage partitioning: B = ceil(NUM_SHIFT_BITS / NUM_STAGES). Stage k applies levels [k·B, min((k+1)·B, NUM_SHIFT_BITS)), then registers the result. Trailing stages with no levels are pure registers.
- Each stage register holds valid, data, shamt, op and sign. sign is the MSB of the original in_data, captured at stage 0.
- Fill rules:
  - SLL: zeros in at LSB.
  - SRL: zeros in at MSB.
  - SRA: the captured sign bit at MSB in every level, never the partially shifted MSB.
  - ROR: bits shifted out at LSB re-enter at MSB.
- shamt = 0 passes data through unchanged for every op.
- Handshake per stage k with valid v[k]:
  - en[last] = !v[last] | out_ready.
  - en[k] = !v[k] | en[k+1].
  - in_ready = en[0].
  - Bubbles collapse: an empty stage accepts data even when downstream is stalled.
- Transfers: input transfer on in_valid & in_ready; output transfer on out_valid & out_ready.
- Output mapping: out_valid = v[last], out_data = data register of the last stage.
- Stalled stage: holds all fields stable. out_data is held while out_valid & !out_ready.
- Order: results emerge in request order; no reordering, no drops except by flush/reset.
- flush: clears every v[k] at the next edge and blocks the capture of any input presented in that cycle. in_ready is still driven by the en chain. Data registers need no clearing.

## Timing
- Reset (rst_n low, asynchronous): all v[k] = 0, out_valid = 0, out_data = 0.
  - in_ready evaluates to 1 combinationally while in reset and afterwards until the pipeline fills.
  - Reset mid-operation discards all in-flight ops; the first valid after release is a newly accepted request.
- Latency: exactly NUM_STAGES cycles from input transfer to out_valid, with no stall.
- Throughput: one op per cycle while out_ready is held high.
- Full pipeline with out_ready low: in_ready = 0 in the same cycle (combinational ready chain). The pipeline holds NUM_STAGES ops maximum.
- Simultaneous output transfer and input transfer in the same cycle are permitted when full; pipeline stays full.
- flush with in_valid & in_ready in the same cycle: the input is dropped; out_valid = 0 the next cycle.
- No combinational path from in_valid/in_data to out_*; out_ready reaches in_ready combinationally.

## Test plan
- NUM_BITS=32, NUM_STAGES=2, streaming, out_ready=1:
  - SRA 0x8000_0000 by 4 → 0xF800_0000.
  - SRL 0xF000_0000 by 28 → 0x0000_000F.
  - SLL 0x0000_0001 by 31 → 0x8000_0000.
  - ROR 0x0000_0001 by 1 → 0x8000_0000.
  - All four back-to-back; each result appears exactly 2 cycles after its transfer, in order.
- Boundary: every op with shamt=0 on 0xA5A5_5A5A → 0xA5A5_5A5A. SRA 0x7FFF_FFFF by 31 → 0x0000_0000. SRA 0xFFFF_FFFF by 31 → 0xFFFF_FFFF.
- Backpressure:
  - Hold out_ready=0 and issue 3 requests: only 2 accepted. in_ready drops after the second; out_data stays stable.
  - Raise out_ready: all results drain in order, one per cycle.
- Bubble collapse: issue one op, gap of one cycle, a second op, out_ready=0. Both are accepted and the pipeline is full after 2 accepts.
- Flush and reset: with 2 ops in flight, flush → out_valid=0 next cycle, no stale result ever emerges. Repeat with rst_n pulsed low mid-cycle → out_valid and out_data go 0 immediately.
- Sweep NUM_STAGES ∈ {1,3,5} with NUM_BITS=32, plus NUM_BITS=8 with NUM_STAGES=3. Random ops compared against a reference model; latency = NUM_STAGES.

Source files
------------

// File: rtl/dl_shifter_pipe.sv
// Pipelined multi-mode barrel shifter (SLL/SRL/SRA/ROR) with valid/ready on both sides.
// The log2 shift network is split evenly across NUM_STAGES registered stages.
module dl_shifter_pipe #(
  parameter  int unsigned NUM_BITS       = 32,
  parameter  int unsigned NUM_STAGES     = 2,
  localparam int unsigned NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_BITS-1:0]       in_data,
  input  logic [NUM_SHIFT_BITS-1:0] in_shamt,
  input  logic [1:0]                in_op,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_BITS-1:0]       out_data
);

  localparam int unsigned LVL_PER_STAGE = (NUM_SHIFT_BITS + NUM_STAGES - 1) / NUM_STAGES;
  localparam int unsigned LAST          = NUM_STAGES - 1;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  // One network level: shift by 2**lvl. SRA fills from the captured sign, not the current MSB.
  function automatic logic [NUM_BITS-1:0] shift_level(
    input logic [NUM_BITS-1:0] d,
    input int unsigned         lvl,
    input logic [1:0]          op,
    input logic                sign
  );
    int unsigned         s;
    logic [NUM_BITS-1:0] fill;
    logic [NUM_BITS-1:0] r;
    s    = 32'd1 << lvl;
    fill = sign ? ~({NUM_BITS{1'b1}} >> s) : '0;
    case (op)
      OP_SLL:  r = d << s;
      OP_SRL:  r = d >> s;
      OP_SRA:  r = (d >> s) | fill;
      default: r = (d >> s) | (d << (NUM_BITS - s));
    endcase
    return r;
  endfunction

  // Levels [lo, hi) of the network, each gated by its shamt bit.
  function automatic logic [NUM_BITS-1:0] stage_net(
    input logic [NUM_BITS-1:0]       d,
    input logic [NUM_SHIFT_BITS-1:0] shamt,
    input logic [1:0]                op,
    input logic                      sign,
    input int unsigned               lo,
    input int unsigned               hi
  );
    logic [NUM_BITS-1:0]       r;
    logic [NUM_SHIFT_BITS-1:0] sh;
    r  = d;
    sh = shamt >> lo;
    for (int unsigned i = lo; i < hi; i++) begin
      if (sh[0]) r = shift_level(r, i, op, sign);
      sh = sh >> 1;
    end
    return r;
  endfunction

  logic [NUM_STAGES-1:0]     v_q;
  logic [NUM_STAGES-1:0]     en;
  logic [NUM_BITS-1:0]       data_q   [NUM_STAGES];
  logic [NUM_SHIFT_BITS-1:0] shamt_q  [NUM_STAGES];
  logic [1:0]                op_q     [NUM_STAGES];
  logic                      sign_q   [NUM_STAGES];

  logic [NUM_STAGES-1:0]     src_v;
  logic [NUM_BITS-1:0]       src_data  [NUM_STAGES];
  logic [NUM_BITS-1:0]       net_data  [NUM_STAGES];
  logic [NUM_SHIFT_BITS-1:0] src_shamt [NUM_STAGES];
  logic [1:0]                src_op    [NUM_STAGES];
  logic                      src_sign  [NUM_STAGES];

  // A stage may load when it or any stage downstream of it is empty, or the sink drains.
  always_comb begin
    logic free;
    en = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      free = out_ready;
      for (int j = k; j < NUM_STAGES; j++) free = free | ~v_q[j];
      en[k] = free;
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int unsigned RAW_LO = unsigned'(k) * LVL_PER_STAGE;
    localparam int unsigned RAW_HI = RAW_LO + LVL_PER_STAGE;
    localparam int unsigned LO     = (RAW_LO < NUM_SHIFT_BITS) ? RAW_LO : NUM_SHIFT_BITS;
    localparam int unsigned HI     = (RAW_HI < NUM_SHIFT_BITS) ? RAW_HI : NUM_SHIFT_BITS;

    if (k == 0) begin : g_head
      assign src_v[k]     = in_valid;
      assign src_data[k]  = in_data;
      assign src_shamt[k] = in_shamt;
      assign src_op[k]    = in_op;
      assign src_sign[k]  = in_data[NUM_BITS-1];
    end else begin : g_body
      assign src_v[k]     = v_q[k-1];
      assign src_data[k]  = data_q[k-1];
      assign src_shamt[k] = shamt_q[k-1];
      assign src_op[k]    = op_q[k-1];
      assign src_sign[k]  = sign_q[k-1];
    end

    assign net_data[k] = stage_net(src_data[k], src_shamt[k], src_op[k], src_sign[k], LO, HI);
  end

  // Stage registers: flush kills every valid; payload only moves when the stage is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        op_q[k]    <= '0;
        sign_q[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (flush)      v_q[k] <= 1'b0;
        else if (en[k]) v_q[k] <= src_v[k];
        if (en[k]) begin
          data_q[k]  <= net_data[k];
          shamt_q[k] <= src_shamt[k];
          op_q[k]    <= src_op[k];
          sign_q[k]  <= src_sign[k];
        end
      end
    end
  end

  assign in_ready  = en[0];
  assign out_valid = v_q[LAST];
  assign out_data  = data_q[LAST];

endmodule

// File: tb/tb_dl_shifter_pipe.sv
// Bench for dl_shifter_pipe: directed scenarios on a 32b/2-stage instance plus a
// randomized sweep of other widths/depths against a per-bit reference shifter.
module tb_dl_shifter_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Main instance: NUM_BITS=32, NUM_STAGES=2
  logic        m_flush = 1'b0, m_in_valid = 1'b0, m_in_ready, m_out_valid, m_out_ready = 1'b0;
  logic [31:0] m_in_data = '0, m_out_data;
  logic [4:0]  m_in_shamt = '0;
  logic [1:0]  m_in_op = '0;

  dl_shifter_pipe #(.NUM_BITS(32), .NUM_STAGES(2)) u_main (
    .clk(clk), .rst_n(rst_n), .flush(m_flush),
    .in_valid(m_in_valid), .in_ready(m_in_ready), .in_data(m_in_data),
    .in_shamt(m_in_shamt), .in_op(m_in_op),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_data(m_out_data));

  // Sweep instances share one stimulus stream, always-ready sink
  logic        s_flush = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b1;
  logic [31:0] s_in_data = '0;
  logic [4:0]  s_in_shamt = '0;
  logic [1:0]  s_in_op = '0;
  logic        sw_valid [4];
  logic        sw_ready [4];
  logic [31:0] sw_data  [4];
  logic [31:0] s1_data, s3_data, s5_data;
  logic [7:0]  s8_data;
  int          lat [4] = '{1, 3, 5, 3};
  int          wid [4] = '{32, 32, 32, 8};

  dl_shifter_pipe #(.NUM_BITS(32), .NUM_STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .in_valid(s_in_valid), .in_ready(sw_ready[0]),
    .in_data(s_in_data), .in_shamt(s_in_shamt), .in_op(s_in_op),
    .out_valid(sw_valid[0]), .out_ready(s_out_ready), .out_data(s1_data));
  dl_shifter_pipe #(.NUM_BITS(32), .NUM_STAGES(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .in_valid(s_in_valid), .in_ready(sw_ready[1]),
    .in_data(s_in_data), .in_shamt(s_in_shamt), .in_op(s_in_op),
    .out_valid(sw_valid[1]), .out_ready(s_out_ready), .out_data(s3_data));
  dl_shifter_pipe #(.NUM_BITS(32), .NUM_STAGES(5)) u_s5 (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .in_valid(s_in_valid), .in_ready(sw_ready[2]),
    .in_data(s_in_data), .in_shamt(s_in_shamt), .in_op(s_in_op),
    .out_valid(sw_valid[2]), .out_ready(s_out_ready), .out_data(s5_data));
  dl_shifter_pipe #(.NUM_BITS(8), .NUM_STAGES(3)) u_s8 (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .in_valid(s_in_valid), .in_ready(sw_ready[3]),
    .in_data(s_in_data[7:0]), .in_shamt(s_in_shamt[2:0]), .in_op(s_in_op),
    .out_valid(sw_valid[3]), .out_ready(s_out_ready), .out_data(s8_data));

  assign sw_data[0] = s1_data;
  assign sw_data[1] = s3_data;
  assign sw_data[2] = s5_data;
  assign sw_data[3] = {24'h0, s8_data};

  // Reference: each result bit picks its source bit directly from the operand.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh,
                                            input logic [1:0] op, input int w);
    logic [31:0] r;
    r = '0;
    for (int b = 0; b < w; b++) begin
      case (op)
        2'd0: if (b >= sh) r[b] = d[b-sh];
        2'd1: if (b + sh < w) r[b] = d[b+sh];
        2'd2: r[b] = (b + sh < w) ? d[b+sh] : d[w-1];
        default: r[b] = d[(b+sh)%w];
      endcase
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op);
    m_in_valid = v;
    m_in_data  = d;
    m_in_shamt = sh;
    m_in_op    = op;
  endtask

  task automatic test_reset;
    #2;
    n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", m_out_valid); end
    n_cmp++; if (m_out_data !== 32'h0) begin n_err++; $display("FAIL reset_data got=%h exp=0", m_out_data); end
    n_cmp++; if (m_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", m_in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_valid got=%b exp=0", m_out_valid); end
  endtask

  task automatic test_stream;
    logic [31:0] d [4], e [4];
    logic [4:0]  sh [4];
    logic [1:0]  op [4];
    d  = '{32'h8000_0000, 32'hF000_0000, 32'h0000_0001, 32'h0000_0001};
    sh = '{5'd4, 5'd28, 5'd31, 5'd1};
    op = '{2'd2, 2'd1, 2'd0, 2'd3};
    e  = '{32'hF800_0000, 32'h0000_000F, 32'h8000_0000, 32'h8000_0000};
    m_out_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      if (t < 4) drive(1'b1, d[t], sh[t], op[t]);
      else       drive(1'b0, '0, '0, '0);
      tick;
      if (t >= 1 && t <= 4) begin
        n_cmp++; if (m_out_valid !== 1'b1 || m_out_data !== e[t-1]) begin
          n_err++; $display("FAIL stream[%0d] got v=%b d=%h exp v=1 d=%h", t-1, m_out_valid, m_out_data, e[t-1]);
        end
      end else begin
        n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL stream_idle[%0d] got v=%b exp 0", t, m_out_valid); end
      end
    end
  endtask

  task automatic test_boundary;
    logic [31:0] d [6], e [6];
    logic [4:0]  sh [6];
    logic [1:0]  op [6];
    d  = '{32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    sh = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31};
    op = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2};
    e  = '{32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 32'h0000_0000, 32'hFFFF_FFFF};
    m_out_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      if (t < 6) drive(1'b1, d[t], sh[t], op[t]);
      else       drive(1'b0, '0, '0, '0);
      tick;
      if (t >= 1 && t <= 6) begin
        n_cmp++; if (m_out_valid !== 1'b1 || m_out_data !== e[t-1]) begin
          n_err++; $display("FAIL boundary[%0d] got v=%b d=%h exp v=1 d=%h", t-1, m_out_valid, m_out_data, e[t-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] a, b, c, ea, eb, ec;
    a = $urandom; b = $urandom; c = $urandom;
    ea = ref_shift(a, 3, 2'd2, 32);
    eb = ref_shift(b, 17, 2'd3, 32);
    ec = ref_shift(c, 9, 2'd0, 32);
    m_out_ready = 1'b0;
    drive(1'b1, a, 5'd3, 2'd2); #1;
    n_cmp++; if (m_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_a got=%b exp=1", m_in_ready); end
    tick;
    drive(1'b1, b, 5'd17, 2'd3); #1;
    n_cmp++; if (m_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_b got=%b exp=1", m_in_ready); end
    tick;
    drive(1'b1, c, 5'd9, 2'd0); #1;
    n_cmp++; if (m_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready got=%b exp=0", m_in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++; if (m_out_valid !== 1'b1 || m_out_data !== ea || m_in_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold[%0d] got v=%b d=%h r=%b exp v=1 d=%h r=0", i, m_out_valid, m_out_data, m_in_ready, ea);
      end
    end
    m_out_ready = 1'b1; #1;
    n_cmp++; if (m_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got=%b exp=1", m_in_ready); end
    tick;
    drive(1'b0, '0, '0, '0);
    n_cmp++; if (m_out_valid !== 1'b1 || m_out_data !== eb) begin n_err++; $display("FAIL bp_drain_b got v=%b d=%h exp %h", m_out_valid, m_out_data, eb); end
    tick;
    n_cmp++; if (m_out_valid !== 1'b1 || m_out_data !== ec) begin n_err++; $display("FAIL bp_drain_c got v=%b d=%h exp %h", m_out_valid, m_out_data, ec); end
    tick;
    n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got v=%b exp 0", m_out_valid); end
  endtask

  task automatic test_bubble;
    logic [31:0] x, y, ex, ey;
    x = $urandom; y = $urandom;
    ex = ref_shift(x, 5, 2'd1, 32);
    ey = ref_shift(y, 30, 2'd2, 32);
    m_out_ready = 1'b0;
    drive(1'b1, x, 5'd5, 2'd1); tick;
    drive(1'b0, '0, '0, '0); tick;
    drive(1'b1, y, 5'd30, 2'd2); #1;
    n_cmp++; if (m_in_ready !== 1'b1) begin n_err++; $display("FAIL bubble_accept got=%b exp=1", m_in_ready); end
    tick;
    drive(1'b1, 32'h1234_5678, 5'd1, 2'd0); #1;
    n_cmp++; if (m_in_ready !== 1'b0 || m_out_valid !== 1'b1 || m_out_data !== ex) begin
      n_err++; $display("FAIL bubble_full got r=%b v=%b d=%h exp r=0 v=1 d=%h", m_in_ready, m_out_valid, m_out_data, ex);
    end
    drive(1'b0, '0, '0, '0);
    m_out_ready = 1'b1;
    tick;
    n_cmp++; if (m_out_valid !== 1'b1 || m_out_data !== ey) begin n_err++; $display("FAIL bubble_drain got v=%b d=%h exp %h", m_out_valid, m_out_data, ey); end
    tick;
    n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL bubble_empty got v=%b exp 0", m_out_valid); end
  endtask

  task automatic test_flush;
    m_out_ready = 1'b0;
    drive(1'b1, $urandom, 5'd2, 2'd0); tick;
    drive(1'b1, $urandom, 5'd7, 2'd1); tick;
    drive(1'b0, '0, '0, '0);
    m_flush = 1'b1; tick; m_flush = 1'b0;
    n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_full got v=%b exp 0", m_out_valid); end
    // flush coinciding with an accepted input drops that input too
    drive(1'b1, $urandom, 5'd4, 2'd3); tick;
    drive(1'b1, $urandom, 5'd8, 2'd2);
    m_flush = 1'b1; #1;
    n_cmp++; if (m_in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got=%b exp=1", m_in_ready); end
    tick;
    m_flush = 1'b0;
    drive(1'b0, '0, '0, '0);
    m_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_stale[%0d] got v=%b exp 0", i, m_out_valid); end
      tick;
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] w, ew;
    w = $urandom; ew = ref_shift(w, 13, 2'd3, 32);
    m_out_ready = 1'b0;
    drive(1'b1, $urandom, 5'd1, 2'd0); tick;
    drive(1'b1, $urandom, 5'd2, 2'd1); tick;
    drive(1'b0, '0, '0, '0);
    @(negedge clk);
    rst_n = 1'b0; #1;
    n_cmp++; if (m_out_valid !== 1'b0 || m_out_data !== 32'h0 || m_in_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_mid got v=%b d=%h r=%b exp v=0 d=0 r=1", m_out_valid, m_out_data, m_in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_release got v=%b exp 0", m_out_valid); end
    m_out_ready = 1'b1;
    drive(1'b1, w, 5'd13, 2'd3); tick;
    drive(1'b0, '0, '0, '0);
    n_cmp++; if (m_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_new_early got v=%b exp 0", m_out_valid); end
    tick;
    n_cmp++; if (m_out_valid !== 1'b1 || m_out_data !== ew) begin n_err++; $display("FAIL rst_new got v=%b d=%h exp %h", m_out_valid, m_out_data, ew); end
    tick;
  endtask

  task automatic test_random_main;
    logic [31:0] q[$];
    logic        acc, xfer, prev_stall;
    logic [31:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      drive(($urandom % 3) != 0, $urandom, 5'($urandom), 2'($urandom));
      m_out_ready = ($urandom % 2) == 0;
      m_flush     = ($urandom % 25) == 0;
      #1;
      n_cmp++; if (m_in_ready !== ((q.size() < 2) || m_out_ready)) begin
        n_err++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", cyc, m_in_ready, (q.size() < 2) || m_out_ready);
      end
      if (prev_stall) begin
        n_cmp++; if (m_out_valid !== 1'b1 || m_out_data !== prev_data) begin
          n_err++; $display("FAIL rnd_stable[%0d] got v=%b d=%h exp v=1 d=%h", cyc, m_out_valid, m_out_data, prev_data);
        end
      end
      if (m_out_valid === 1'b1) begin
        n_cmp++; if (q.size() == 0) begin n_err++; $display("FAIL rnd_spurious[%0d] got v=1 exp nothing pending", cyc); end
        else if (m_out_data !== q[0]) begin n_err++; $display("FAIL rnd_data[%0d] got=%h exp=%h", cyc, m_out_data, q[0]); end
      end
      xfer = m_out_valid && m_out_ready;
      acc  = m_in_valid && m_in_ready && !m_flush;
      if (xfer && q.size() > 0) void'(q.pop_front());
      if (m_flush) q.delete();
      if (acc) q.push_back(ref_shift(m_in_data, int'(m_in_shamt), m_in_op, 32));
      prev_stall = m_out_valid && !m_out_ready && !m_flush;
      prev_data  = m_out_data;
      @(posedge clk); #1;
    end
    drive(1'b0, '0, '0, '0);
    m_flush = 1'b0;
    m_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (m_out_valid === 1'b1) begin
        n_cmp++; if (q.size() == 0 || m_out_data !== q[0]) begin
          n_err++; $display("FAIL rnd_drain[%0d] got=%h exp=%h", i, m_out_data, (q.size() > 0) ? q[0] : 32'h0);
        end
        if (q.size() > 0) void'(q.pop_front());
      end
      tick;
    end
    n_cmp++; if (q.size() != 0 || m_out_valid !== 1'b0) begin
      n_err++; $display("FAIL rnd_left got pending=%0d v=%b exp pending=0 v=0", q.size(), m_out_valid);
    end
  endtask

  task automatic test_sweep;
    logic        hv  [200];
    logic [31:0] hd  [200];
    logic [4:0]  hsh [200];
    logic [1:0]  hop [200];
    logic        ev;
    logic [31:0] ed;
    int          idx;
    for (int cyc = 0; cyc < 200; cyc++) begin
      s_in_valid = ($urandom % 4) != 0;
      s_in_data  = $urandom;
      s_in_shamt = 5'($urandom);
      s_in_op    = 2'($urandom);
      hv[cyc] = s_in_valid; hd[cyc] = s_in_data; hsh[cyc] = s_in_shamt; hop[cyc] = s_in_op;
      #1;
      for (int j = 0; j < 4; j++) begin
        n_cmp++; if (sw_ready[j] !== 1'b1) begin n_err++; $display("FAIL sweep_ready[%0d][%0d] got=%b exp=1", j, cyc, sw_ready[j]); end
      end
      tick;
      for (int j = 0; j < 4; j++) begin
        idx = cyc + 1 - lat[j];
        ev  = (idx >= 0) ? hv[idx] : 1'b0;
        n_cmp++; if (sw_valid[j] !== ev) begin
          n_err++; $display("FAIL sweep_valid[%0d][%0d] got=%b exp=%b", j, cyc, sw_valid[j], ev);
        end else if (ev) begin
          if (wid[j] == 8) ed = ref_shift(hd[idx] & 32'hFF, int'(hsh[idx]) % 8, hop[idx], 8);
          else             ed = ref_shift(hd[idx], int'(hsh[idx]), hop[idx], 32);
          n_cmp++; if (sw_data[j] !== ed) begin
            n_err++; $display("FAIL sweep_data[%0d][%0d] got=%h exp=%h", j, cyc, sw_data[j], ed);
          end
        end
      end
    end
    s_in_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_stream;
    test_boundary;
    test_backpressure;
    test_bubble;
    test_flush;
    test_reset_mid;
    test_random_main;
    test_sweep;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=timeout exp=completion");
    $fatal(1, "watchdog");
  end

endmodule
